// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register word
// offsets, STATUS/CTRL bit positions, FSM state encoding and reset baud divisor.
package uart_tx_pkg;

   localparam logic [1:0] REG_TX_DATA  = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_BAUD_DIV = 2'd2;
   localparam logic [1:0] REG_CTRL     = 2'd3;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVR     = 3;
   localparam int ST_CNT_LSB = 4;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_PAR_ODD = 1;

   // 50 MHz / 115200 baud
   localparam int DEFAULT_BAUD_DIV = 434;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus slot as seen by a peripheral: the controller (master) drives
// address/data/strobe, the peripheral (slave) returns combinational read data.
interface uart_tx_mmio_if #(
   parameter int DATA_WIDTH = 32
);
   logic [31:0]           in_address;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_write_en;
   logic [DATA_WIDTH-1:0] out_read_data;

   modport master (output in_address, output in_data, output in_write_en,
                   input out_read_data);
   modport slave  (input in_address, input in_data, input in_write_en,
                   output out_read_data);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous TX FIFO. The head entry is visible combinationally so the
// transmitter can pop and load its shift register on the same edge. A push
// into a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Storage array; reset only clears the pointers, stale data is never read
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is 2^n
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter (register file, baud counter, frame FSM).
// Optional: define UART_TX_PARITY_EN to add CTRL.PAR_ODD and a parity bit.
module uart_tx_mmio #(
   parameter int FIFO_DEPTH       = 4,
   parameter int DEFAULT_BAUD_DIV = uart_tx_pkg::DEFAULT_BAUD_DIV,
   parameter int DATA_WIDTH       = 32
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_mmio_if.slave  bus,
   output logic           tx_out,
   output logic           irq_out
);
   import uart_tx_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]  addr;
   logic        wr_tx, wr_status, wr_baud, wr_ctrl;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_head;
   logic [CW-1:0] fifo_count;

   logic [15:0] baud_div_q;
   logic        en_q, ovr_q;
   tx_state_t   state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [15:0] cur_div_q, cur_div_d;
   logic        tx_q, tx_d;
   logic        bit_done, can_start, start_frame;
   logic [DATA_WIDTH-1:0] rdata;
`ifdef UART_TX_PARITY_EN
   logic        par_odd_q;
   logic        parity_q, parity_d;
`endif

   logic unused_bits;
   assign unused_bits = ^{bus.in_address[31:2], bus.in_data[DATA_WIDTH-1:16]};

   assign addr      = bus.in_address[1:0];
   assign wr_tx     = bus.in_write_en && (addr == REG_TX_DATA);
   assign wr_status = bus.in_write_en && (addr == REG_STATUS);
   assign wr_baud   = bus.in_write_en && (addr == REG_BAUD_DIV);
   assign wr_ctrl   = bus.in_write_en && (addr == REG_CTRL);

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_tx),
      .data_i  (bus.in_data[7:0]),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Software-visible registers; OVR is set on a dropped push, cleared by any STATUS write
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_div_q <= 16'(DEFAULT_BAUD_DIV);
         en_q       <= 1'b1;
         ovr_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_odd_q  <= 1'b0;
`endif
      end else begin
         if (wr_baud)
            baud_div_q <= (bus.in_data[15:0] == 16'd0) ? 16'd1 : bus.in_data[15:0];
         if (wr_ctrl) begin
            en_q <= bus.in_data[CTRL_EN];
`ifdef UART_TX_PARITY_EN
            par_odd_q <= bus.in_data[CTRL_PAR_ODD];
`endif
         end
         if (wr_status)
            ovr_q <= 1'b0;
         else if (wr_tx && fifo_full && !fifo_pop)
            ovr_q <= 1'b1;
      end
   end

   assign bit_done  = (baud_cnt_q == cur_div_q - 16'd1);
   assign can_start = en_q && !fifo_empty;

   // Frame FSM state and registered serial output
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tx_q       <= 1'b1;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
         cur_div_q  <= 16'(DEFAULT_BAUD_DIV);
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_cnt_q <= baud_cnt_d;
         cur_div_q  <= cur_div_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   // Next state: tx_d carries the line level of the state being entered, so
   // the line changes on the same edge as the state register
   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      baud_cnt_d  = baud_cnt_q + 16'd1;
      cur_div_d   = cur_div_q;
      fifo_pop    = 1'b0;
      start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            baud_cnt_d  = '0;
            tx_d        = 1'b1;
            start_frame = can_start;
         end
         S_START: if (bit_done) begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_DATA;
            tx_d       = shift_q[0];
            shift_d    = {1'b0, shift_q[7:1]};
         end
         S_DATA: if (bit_done) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
               tx_d    = parity_q;
`else
               state_d = S_STOP;
               tx_d    = 1'b1;
`endif
            end else begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (bit_done) begin
            baud_cnt_d = '0;
            state_d    = S_STOP;
            tx_d       = 1'b1;
         end
`endif
         S_STOP: if (bit_done) begin
            baud_cnt_d  = '0;
            state_d     = S_IDLE;
            tx_d        = 1'b1;
            start_frame = can_start;
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
      // Frame start from IDLE or straight out of STOP; divisor sampled here
      if (start_frame) begin
         fifo_pop   = 1'b1;
         shift_d    = fifo_head;
         cur_div_d  = baud_div_q;
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
         tx_d       = 1'b0;
         state_d    = S_START;
`ifdef UART_TX_PARITY_EN
         parity_d   = (^fifo_head) ^ par_odd_q;
`endif
      end
   end

   // Combinational load data so single-cycle loads complete immediately
   always_comb begin
      rdata = '0;
      case (addr)
         REG_STATUS: begin
            rdata[ST_BUSY]             = (state_q != S_IDLE);
            rdata[ST_FULL]             = fifo_full;
            rdata[ST_EMPTY]            = fifo_empty;
            rdata[ST_OVR]              = ovr_q;
            rdata[ST_CNT_LSB+3:ST_CNT_LSB] = 4'(fifo_count);
         end
         REG_BAUD_DIV: rdata[15:0] = baud_div_q;
         REG_CTRL: begin
            rdata[CTRL_EN] = en_q;
`ifdef UART_TX_PARITY_EN
            rdata[CTRL_PAR_ODD] = par_odd_q;
`endif
         end
         default: rdata = '0;
      endcase
   end

   assign bus.out_read_data = rdata;
   assign tx_out  = tx_q;
   assign irq_out = fifo_empty && (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio: register reads, frame waveforms,
// FIFO overflow, back-to-back frames, mid-frame reset and baud changes.
module tb_uart_tx_mmio;

   logic clk;
   logic rst;
   logic tx_out;
   logic irq_out;

   uart_tx_mmio_if #(.DATA_WIDTH(32)) bus_if ();

   uart_tx_mmio dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if.slave),
      .tx_out  (tx_out),
      .irq_out (irq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [255:0] cap_tx, cap_busy, cap_irq;

   // One store on the bus; returns 1 time unit after the capturing edge
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_if.in_address  = {30'd0, a};
      bus_if.in_data     = d;
      bus_if.in_write_en = 1'b1;
      @(posedge clk);
      #1;
      bus_if.in_write_en = 1'b0;
      $display("[TB] write addr=%0d data=0x%08h", a, d);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_if.in_address  = {30'd0, a};
      bus_if.in_write_en = 1'b0;
      #1;
      d = bus_if.out_read_data;
      $display("[TB] read  addr=%0d data=0x%08h", a, d);
   endtask

   // Record tx_out, STATUS.BUSY and irq_out after each of the next n edges
   task automatic capture(input int n);
      cap_tx   = '1;
      cap_busy = '0;
      cap_irq  = '0;
      bus_if.in_address  = 32'd1;
      bus_if.in_write_en = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cap_tx[i]   = tx_out;
         cap_busy[i] = bus_if.out_read_data[0];
         cap_irq[i]  = irq_out;
      end
   endtask

   // Expected line levels of one frame placed at sample offset off
   function automatic logic [255:0] put_frame(input logic [255:0] v, input int off,
                                              input logic [7:0] b, input int div,
                                              input int has_par, input logic par_bit);
      logic [255:0] r;
      logic         val;
      int           nb;
      r  = v;
      nb = has_par ? 11 : 10;
      for (int i = 0; i < nb; i++) begin
         if (i == 0)                    val = 1'b0;
         else if (i <= 8)               val = b[i-1];
         else if (has_par != 0 && i == 9) val = par_bit;
         else                           val = 1'b1;
         for (int j = 0; j < div; j++) r[off + i*div + j] = val;
      end
      return r;
   endfunction

   function automatic logic [255:0] ones_mask(input int n);
      logic [255:0] m;
      m = '1;
      return m >> (256 - n);
   endfunction

   task automatic test_reset();
      logic [31:0] rd;
      rst = 1'b1;
      bus_if.in_write_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tests_run++;
      if (tx_out !== 1'b1) begin tests_failed++; $display("FAIL reset_tx got %b exp 1", tx_out); end
      tests_run++;
      if (irq_out !== 1'b1) begin tests_failed++; $display("FAIL reset_irq got %b exp 1", irq_out); end
      bus_read(2'd1, rd);
      tests_run++;
      if (rd !== 32'h4) begin tests_failed++; $display("FAIL reset_status got 0x%0h exp 0x4", rd); end
      bus_read(2'd2, rd);
      tests_run++;
      if (rd !== 32'd434) begin tests_failed++; $display("FAIL reset_baud got %0d exp 434", rd); end
      bus_read(2'd3, rd);
      tests_run++;
      if (rd !== 32'h1) begin tests_failed++; $display("FAIL reset_ctrl got 0x%0h exp 0x1", rd); end
      bus_read(2'd0, rd);
      tests_run++;
      if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_txdata got 0x%0h exp 0x0", rd); end
   endtask

   task automatic test_single_frame();
      logic [255:0] exp_tx, exp_busy, exp_irq, m;
      bus_write(2'd2, 32'd4);
      bus_write(2'd0, 32'h55);
      capture(48);
      m = ones_mask(48);
      exp_tx   = put_frame('1, 0, 8'h55, 4, 0, 1'b0);
      exp_busy = ones_mask(40);
      exp_irq  = ~exp_busy;
      tests_run++;
      if ((cap_tx & m) !== (exp_tx & m)) begin
         tests_failed++; $display("FAIL frame55_tx got %h exp %h", cap_tx & m, exp_tx & m);
      end
      tests_run++;
      if ((cap_busy & m) !== (exp_busy & m)) begin
         tests_failed++; $display("FAIL frame55_busy got %h exp %h", cap_busy & m, exp_busy & m);
      end
      tests_run++;
      if ((cap_irq & m) !== (exp_irq & m)) begin
         tests_failed++; $display("FAIL frame55_irq got %h exp %h", cap_irq & m, exp_irq & m);
      end
   endtask

   task automatic test_overflow_back_to_back();
      logic [31:0]  rd;
      logic [255:0] exp_tx, exp_busy, m;
      bus_write(2'd2, 32'd2);
      bus_write(2'd3, 32'd0);
      for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'(i));
      bus_read(2'd1, rd);
      tests_run++;
      if (rd !== 32'h4A) begin tests_failed++; $display("FAIL ovf_status got 0x%0h exp 0x4a", rd); end
      tests_run++;
      if (tx_out !== 1'b1) begin tests_failed++; $display("FAIL ovf_tx_idle got %b exp 1", tx_out); end
      bus_write(2'd1, 32'd0);
      bus_read(2'd1, rd);
      tests_run++;
      if (rd !== 32'h42) begin tests_failed++; $display("FAIL ovr_clear got 0x%0h exp 0x42", rd); end
      bus_write(2'd3, 32'd1);
      capture(88);
      m = ones_mask(88);
      exp_tx = '1;
      for (int f = 0; f < 4; f++) exp_tx = put_frame(exp_tx, 20*f, 8'(f+1), 2, 0, 1'b0);
      exp_busy = ones_mask(80);
      tests_run++;
      if ((cap_tx & m) !== (exp_tx & m)) begin
         tests_failed++; $display("FAIL b2b_tx got %h exp %h", cap_tx & m, exp_tx & m);
      end
      tests_run++;
      if ((cap_busy & m) !== (exp_busy & m)) begin
         tests_failed++; $display("FAIL b2b_busy got %h exp %h", cap_busy & m, exp_busy & m);
      end
      bus_read(2'd1, rd);
      tests_run++;
      if (rd !== 32'h4) begin tests_failed++; $display("FAIL b2b_end_status got 0x%0h exp 0x4", rd); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] rd;
      bus_write(2'd2, 32'd4);
      bus_write(2'd0, 32'hA5);
      capture(17);   // last sample lies inside data bit 3
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tests_run++;
      if (tx_out !== 1'b1) begin tests_failed++; $display("FAIL midrst_tx got %b exp 1", tx_out); end
      bus_read(2'd1, rd);
      tests_run++;
      if (rd !== 32'h4) begin tests_failed++; $display("FAIL midrst_status got 0x%0h exp 0x4", rd); end
      bus_read(2'd2, rd);
      tests_run++;
      if (rd !== 32'd434) begin tests_failed++; $display("FAIL midrst_baud got %0d exp 434", rd); end
      capture(10);
      tests_run++;
      if (cap_tx[9:0] !== 10'h3FF) begin
         tests_failed++; $display("FAIL midrst_abandon got %h exp 3ff", cap_tx[9:0]);
      end
      tests_run++;
      if (irq_out !== 1'b1) begin tests_failed++; $display("FAIL midrst_irq got %b exp 1", irq_out); end
   endtask

   task automatic test_baud_change();
      logic [31:0]  rd;
      logic [255:0] exp_tx, m;
      bus_write(2'd3, 32'd0);
      bus_write(2'd2, 32'd0);
      bus_read(2'd2, rd);
      tests_run++;
      if (rd !== 32'd1) begin tests_failed++; $display("FAIL baud_zero got %0d exp 1", rd); end
      bus_write(2'd2, 32'd4);
      bus_write(2'd0, 32'h0F);
      bus_write(2'd0, 32'hF0);
      bus_write(2'd3, 32'd1);
      // This store lands on the frame-start edge: first frame keeps divisor 4
      bus_write(2'd2, 32'd8);
      capture(125);
      m = ones_mask(125);
      exp_tx = put_frame('1, 0, 8'h0F, 4, 0, 1'b0);
      exp_tx = put_frame(exp_tx, 40, 8'hF0, 8, 0, 1'b0);
      exp_tx = exp_tx >> 1;   // sample 0 was taken up by the BAUD_DIV store
      tests_run++;
      if ((cap_tx & m) !== (exp_tx & m)) begin
         tests_failed++; $display("FAIL baud_change_tx got %h exp %h", cap_tx & m, exp_tx & m);
      end
      bus_read(2'd2, rd);
      tests_run++;
      if (rd !== 32'd8) begin tests_failed++; $display("FAIL baud_readback got %0d exp 8", rd); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [31:0]  rd;
      logic [255:0] exp_tx, exp_busy, m;
      m = ones_mask(24);
      bus_write(2'd2, 32'd2);
      bus_write(2'd0, 32'h07);
      capture(24);
      exp_tx   = put_frame('1, 0, 8'h07, 2, 1, 1'b1);
      exp_busy = ones_mask(22);
      tests_run++;
      if ((cap_tx & m) !== (exp_tx & m)) begin
         tests_failed++; $display("FAIL parity_even got %h exp %h", cap_tx & m, exp_tx & m);
      end
      tests_run++;
      if ((cap_busy & m) !== (exp_busy & m)) begin
         tests_failed++; $display("FAIL parity_len got %h exp %h", cap_busy & m, exp_busy & m);
      end
      bus_write(2'd3, 32'd3);
      bus_read(2'd3, rd);
      tests_run++;
      if (rd !== 32'h3) begin tests_failed++; $display("FAIL parity_ctrl got 0x%0h exp 0x3", rd); end
      bus_write(2'd0, 32'h07);
      capture(24);
      exp_tx = put_frame('1, 0, 8'h07, 2, 1, 1'b0);
      tests_run++;
      if ((cap_tx & m) !== (exp_tx & m)) begin
         tests_failed++; $display("FAIL parity_odd got %h exp %h", cap_tx & m, exp_tx & m);
      end
   endtask
`else
   task automatic test_ctrl_bit1();
      logic [31:0] rd;
      bus_write(2'd3, 32'd3);
      bus_read(2'd3, rd);
      tests_run++;
      if (rd !== 32'h1) begin tests_failed++; $display("FAIL ctrl_bit1 got 0x%0h exp 0x1", rd); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus_if.in_address  = '0;
      bus_if.in_data     = '0;
      bus_if.in_write_en = 1'b0;
      test_reset();
      test_single_frame();
      test_overflow_back_to_back();
      test_reset_midframe();
      test_baud_change();
`ifdef UART_TX_PARITY_EN
      test_parity();
`else
      test_ctrl_bit1();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
